// File: rtl/rsa_modexp_arbiter.sv
// Round-robin arbiter for two requesters sharing one mod-exp core; 8-cycle minimum request-to-response latency.
// Define RSA_ARB_TIMEOUT_EN to add a WAIT watchdog that aborts with an error after TIMEOUT_CYCLES cycles.
module rsa_modexp_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned DW             = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [1:0]      req_valid_i,
  output logic [1:0]      req_ready_o,
  input  logic [2*DW-1:0] req_msg_i,
  input  logic [2*DW-1:0] req_exp_i,
  input  logic [2*DW-1:0] req_mod_i,
  output logic [1:0]      rsp_valid_o,
  input  logic [1:0]      rsp_ready_i,
  output logic [DW-1:0]   rsp_data_o,
  output logic            rsp_err_o,
  output logic            core_wr_o,
  output logic [1:0]      core_sel_o,
  output logic [DW-1:0]   core_wdata_o,
  output logic            core_start_o,
  input  logic            core_ready_i,
  output logic            core_rd_o,
  input  logic [DW-1:0]   core_rdata_i
);

  typedef enum logic [2:0] {IDLE, LD_MSG, LD_EXP, LD_MOD, START, WAIT, READ, RESP} state_t;

  state_t        state, state_nxt;
  logic          run, owner, last;
  logic [DW-1:0] msg_q, exp_q, mod_q, data_q, sel_mod;
  logic          err_q, rd_pend, wait_first;
  logic [1:0]    grant;
  logic          gnt_idx, take, mod_zero, timeout;

  // Both valid: favour the one not granted last; otherwise whoever is valid.
  always_comb begin
    grant = req_valid_i;
    if (req_valid_i == 2'b11) grant = last ? 2'b01 : 2'b10;
  end

  assign gnt_idx  = grant[1];
  assign take     = run && (state == IDLE) && (grant != 2'b00);
  assign sel_mod  = gnt_idx ? req_mod_i[2*DW-1:DW] : req_mod_i[DW-1:0];
  assign mod_zero = (sel_mod == '0);

`ifdef RSA_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)               wait_cnt <= '0;
    else if (state == START)   wait_cnt <= '0;
    else if (state == WAIT)    wait_cnt <= wait_cnt + 1'b1;
  end

  assign timeout = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    req_ready_o  = 2'b00;
    rsp_valid_o  = 2'b00;
    core_wr_o    = 1'b0;
    core_sel_o   = 2'd0;
    core_wdata_o = '0;
    core_start_o = 1'b0;
    core_rd_o    = 1'b0;
    case (state)
      IDLE: begin
        if (run) req_ready_o = grant;
        if (take) state_nxt = mod_zero ? RESP : LD_MSG;
      end
      LD_MSG: begin
        core_wr_o    = 1'b1;
        core_sel_o   = 2'd0;
        core_wdata_o = msg_q;
        state_nxt    = LD_EXP;
      end
      LD_EXP: begin
        core_wr_o    = 1'b1;
        core_sel_o   = 2'd1;
        core_wdata_o = exp_q;
        state_nxt    = LD_MOD;
      end
      LD_MOD: begin
        core_wr_o    = 1'b1;
        core_sel_o   = 2'd2;
        core_wdata_o = mod_q;
        state_nxt    = START;
      end
      START: begin
        core_start_o = 1'b1;
        state_nxt    = WAIT;
      end
      // core_ready_i may still show the previous idle state in the first cycle.
      WAIT: begin
        if (!wait_first && core_ready_i) state_nxt = READ;
        else if (timeout)                state_nxt = RESP;
      end
      READ: begin
        core_rd_o = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid_o = owner ? 2'b10 : 2'b01;
        if (rsp_ready_i[owner]) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read data arrives in the first RESP cycle; pass it through then, hold the captured copy after.
  assign rsp_data_o = rd_pend ? core_rdata_i : data_q;
  assign rsp_err_o  = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run        <= 1'b0;
      owner      <= 1'b0;
      last       <= 1'b1;
      msg_q      <= '0;
      exp_q      <= '0;
      mod_q      <= '0;
      data_q     <= '0;
      err_q      <= 1'b0;
      rd_pend    <= 1'b0;
      wait_first <= 1'b0;
    end else begin
      run        <= 1'b1;
      rd_pend    <= (state == READ);
      wait_first <= (state == START);
      if (take) begin
        owner <= gnt_idx;
        last  <= gnt_idx;
        msg_q <= gnt_idx ? req_msg_i[2*DW-1:DW] : req_msg_i[DW-1:0];
        exp_q <= gnt_idx ? req_exp_i[2*DW-1:DW] : req_exp_i[DW-1:0];
        mod_q <= sel_mod;
        err_q <= mod_zero;
        if (mod_zero) data_q <= '0;
      end
      if (rd_pend) data_q <= core_rdata_i;
      if (state == WAIT && state_nxt == RESP) begin
        data_q <= '0;
        err_q  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rsa_modexp_arbiter.sv
// Directed bench for rsa_modexp_arbiter with a behavioural mod-exp core model.
module tb_rsa_modexp_arbiter;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i, core_sel_o;
  logic [63:0] req_msg_i, req_exp_i, req_mod_i;
  logic [31:0] rsp_data_o, core_wdata_o, core_rdata_i;
  logic        rsp_err_o, core_wr_o, core_start_o, core_ready_i, core_rd_o;

  rsa_modexp_arbiter #(.TIMEOUT_CYCLES(16), .DW(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_msg_i(req_msg_i), .req_exp_i(req_exp_i), .req_mod_i(req_mod_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
    .core_wr_o(core_wr_o), .core_sel_o(core_sel_o), .core_wdata_o(core_wdata_o),
    .core_start_o(core_start_o), .core_ready_i(core_ready_i),
    .core_rd_o(core_rd_o), .core_rdata_i(core_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int ncmp = 0, nerr = 0, cyc = 0, wr_cnt = 0, start_cnt = 0;
  int hs, rc, w0, s0, delay = 1;
  bit core_hold = 1'b0;
  logic [31:0] cm_msg = '0, cm_exp = '0, cm_mod = '0, cm_res = '0;
  int busy = 0;
  logic rd_d = 1'b0;

  function automatic logic [31:0] modexp(input logic [31:0] b, input logic [31:0] e, input logic [31:0] m);
    longint unsigned r, x, mm;
    if (m == 0) return 32'h0;
    mm = longint'(m);
    r  = 64'd1 % mm;
    x  = longint'(b) % mm;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) r = (r * x) % mm;
      x = (x * x) % mm;
    end
    return r[31:0];
  endfunction

  always @(posedge clk_i) begin
    cyc++;
    if (core_wr_o) wr_cnt++;
    if (core_start_o) start_cnt++;
  end

  always @(posedge clk_i) begin
    if (core_wr_o) begin
      case (core_sel_o)
        2'd0:    cm_msg <= core_wdata_o;
        2'd1:    cm_exp <= core_wdata_o;
        default: cm_mod <= core_wdata_o;
      endcase
    end
    if (core_start_o) begin
      cm_res <= modexp(cm_msg, cm_exp, cm_mod);
      busy   <= delay;
    end else if (busy > 0) busy <= busy - 1;
    rd_d <= core_rd_o;
  end

  assign core_ready_i = !core_hold && (busy == 0);
  assign core_rdata_i = rd_d ? cm_res : 32'hDEADBEEF;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {54'd0, req_ready_o, rsp_valid_o, rsp_err_o, core_wr_o,
                        core_sel_o, core_start_o, core_rd_o}, 64'd0);
    chk({tag, "_data"}, {32'd0, rsp_data_o}, 64'd0);
    chk({tag, "_wdata"}, {32'd0, core_wdata_o}, 64'd0);
  endtask

  task automatic set_op(input int n, input logic [31:0] m, input logic [31:0] e, input logic [31:0] md);
    req_msg_i[n*32 +: 32] = m;
    req_exp_i[n*32 +: 32] = e;
    req_mod_i[n*32 +: 32] = md;
  endtask

  task automatic wait_grant(input string tag, output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (req_ready_o != 2'b00) begin
        c = cyc;
        return;
      end
    end
    ncmp++;
    nerr++;
    $error("FAIL %s: no grant within 40 cycles", tag);
  endtask

  task automatic wait_rsp(input string tag, output int c);
    c = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o != 2'b00) begin
        c = cyc;
        return;
      end
    end
    ncmp++;
    nerr++;
    $error("FAIL %s: no response within 100 cycles", tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  own_t [4];
    logic [31:0] res_t [4];
    own_t = '{2'b01, 2'b10, 2'b01, 2'b10};
    res_t = '{32'd24, 32'd43, 32'd6, 32'd9};

    rst_ni = 1'b0; req_valid_i = 2'b11; rsp_ready_i = 2'b00;
    req_msg_i = '0; req_exp_i = '0; req_mod_i = '0;
    #12;
    chk_zero("reset");
    req_valid_i = 2'b00;
    @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    // Basic transaction, requester 0
    set_op(0, 32'd4, 32'd13, 32'h1F1);
    req_valid_i = 2'b01;
    wait_grant("t1", hs);
    chk("t1_grant", {62'd0, req_ready_o}, 64'b01);
    w0 = wr_cnt; s0 = start_cnt;
    @(posedge clk_i); #1 req_valid_i = 2'b00;
    wait_rsp("t1", rc);
    chk("t1_latency", rc - hs, 64'd8);
    chk("t1_valid", {62'd0, rsp_valid_o}, 64'b01);
    chk("t1_data", {32'd0, rsp_data_o}, 64'h1BD);
    chk("t1_err", {63'd0, rsp_err_o}, 64'd0);
    chk("t1_core_ops", {cm_msg, cm_exp}, {32'd4, 32'hD});
    chk("t1_core_mod", {32'd0, cm_mod}, 64'h1F1);
    chk("t1_core_cnt", {32'(wr_cnt - w0), 32'(start_cnt - s0)}, {32'd3, 32'd1});
    rsp_ready_i = 2'b01;
    @(posedge clk_i); #1 rsp_ready_i = 2'b00;
    @(negedge clk_i);
    chk("t1_done", {62'd0, rsp_valid_o}, 64'd0);

    // Modulus zero from requester 1, then stall the response for 10 cycles
    delay = 0;
    @(posedge clk_i); #1;
    set_op(1, 32'd9, 32'd5, 32'd0);
    req_valid_i = 2'b10;
    wait_grant("mz", hs);
    chk("mz_grant", {62'd0, req_ready_o}, 64'b10);
    w0 = wr_cnt; s0 = start_cnt;
    @(posedge clk_i); #1;
    set_op(0, 32'd2, 32'd10, 32'd1000);
    set_op(1, 32'd3, 32'd5, 32'd100);
    req_valid_i = 2'b11;
    rsp_ready_i = 2'b01;
    wait_rsp("mz", rc);
    chk("mz_latency", rc - hs, 64'd1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_stable", {rsp_valid_o, rsp_err_o, req_ready_o, rsp_data_o},
          {2'b10, 1'b1, 2'b00, 32'd0});
      @(negedge clk_i);
    end
    chk("mz_core_cnt", {32'(wr_cnt - w0), 32'(start_cnt - s0)}, 64'd0);
    @(posedge clk_i); #1 rsp_ready_i = 2'b11;
    @(negedge clk_i);
    chk("hold_release", {62'd0, rsp_valid_o}, 64'b10);

    // Both requesters contending: alternate grants
    for (int k = 0; k < 4; k++) begin
      wait_grant("rr", hs);
      chk("rr_grant", {62'd0, req_ready_o}, {62'd0, own_t[k]});
      @(posedge clk_i); #1;
      case (k)
        0: set_op(0, 32'd5, 32'd3, 32'd7);
        1: set_op(1, 32'd7, 32'd2, 32'd10);
        2: req_valid_i[0] = 1'b0;
        default: req_valid_i[1] = 1'b0;
      endcase
      wait_rsp("rr", rc);
      chk("rr_latency", rc - hs, 64'd8);
      chk("rr_owner", {62'd0, rsp_valid_o}, {62'd0, own_t[k]});
      chk("rr_data", {31'd0, rsp_err_o, rsp_data_o}, {32'd0, res_t[k]});
    end
    @(posedge clk_i); #1 rsp_ready_i = 2'b00;

    // Reset in WAIT, then pointer favours requester 0 again
    core_hold = 1'b1;
    set_op(0, 32'h01234567, 32'h89ABCDEF, 32'h11111111);
    req_valid_i = 2'b01;
    wait_grant("rw", hs);
    @(posedge clk_i); #1;
    set_op(1, 32'd3, 32'd3, 32'd5);
    req_valid_i = 2'b11;
    repeat (5) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    chk_zero("mid_reset");
    core_hold = 1'b0;
    @(posedge clk_i); #1 rst_ni = 1'b1;
    rsp_ready_i = 2'b11;
    wait_grant("rw0", hs);
    chk("rw_grant0", {62'd0, req_ready_o}, 64'b01);
    @(posedge clk_i); #1 req_valid_i = 2'b10;
    wait_rsp("rw0", rc);
    chk("rw_rsp0", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b01, 1'b0, 32'h0D9EF081});
    wait_grant("rw1", hs);
    chk("rw_grant1", {62'd0, req_ready_o}, 64'b10);
    @(posedge clk_i); #1 req_valid_i = 2'b00;
    wait_rsp("rw1", rc);
    chk("rw_rsp1", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b10, 1'b0, 32'd2});
    @(posedge clk_i); #1 rsp_ready_i = 2'b00;

    // Core never ready
    core_hold = 1'b1;
    set_op(0, 32'd2, 32'd3, 32'd7);
    req_valid_i = 2'b01;
    wait_grant("to", hs);
    @(posedge clk_i); #1 req_valid_i = 2'b00;
`ifdef RSA_ARB_TIMEOUT_EN
    wait_rsp("to", rc);
    chk("to_latency", rc - hs, 64'd21);
    chk("to_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b01, 1'b1, 32'd0});
    core_hold = 1'b0;
`else
    repeat (60) @(negedge clk_i);
    chk("no_timeout", {62'd0, rsp_valid_o}, 64'd0);
    core_hold = 1'b0;
    wait_rsp("to", rc);
    chk("wait_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, {2'b01, 1'b0, 32'd1});
`endif
    @(posedge clk_i); #1 rsp_ready_i = 2'b01;
    @(posedge clk_i); #1 rsp_ready_i = 2'b00;
    @(negedge clk_i);
    chk("final_idle", {62'd0, rsp_valid_o}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
